// File: rtl/seq_divider.sv
// seq_divider: iterative signed restoring divider, one quotient bit per clock.
// Ports: start/dividend/divisor in; lo (quotient), hi (remainder), busy, done, div0 out.
// Latency: start edge to done high is WIDTH+1 cycles.
// Backpressure: none. start is ignored while busy, and a new start is accepted in the done cycle.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             busy,
  output logic             done,
  output logic             div0
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] quo_q, quo_d;   // dividend bits shift out the top, quotient bits shift in the bottom
  logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder
  logic [WIDTH-1:0] dvs_q, dvs_d;   // |divisor|
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qsign_q, qsign_d;
  logic             rsign_q, rsign_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div0_q, div0_d;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;

  // The shifted remainder stays below 2*|divisor|, so WIDTH+1 bits suffice.
  // The top bit of the trial result is the borrow, meaning "restore".
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    qsign_d = qsign_q;
    rsign_d = rsign_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    div0_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            div0_d = 1'b1;
          end else begin
            qsign_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            rsign_d = dividend[WIDTH-1];
            // The most negative value negates to itself, which is the correct unsigned magnitude.
            quo_d   = dividend[WIDTH-1] ? -dividend : dividend;
            dvs_d   = divisor[WIDTH-1]  ? -divisor  : divisor;
            rem_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (trial[WIDTH]) begin
          rem_d = rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end else begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        lo_d    = qsign_q ? -quo_q : quo_q;
        hi_d    = rsign_q ? -rem_q : rem_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      div0_q  <= div0_d;
    end
  end

  assign lo   = lo_q;
  assign hi   = hi_q;
  assign busy = busy_q;
  assign done = done_q;
  assign div0 = div0_q;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] lo;
  logic [31:0] hi;
  logic        busy;
  logic        done;
  logic        div0;

  int total = 0;
  int bad   = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .lo       (lo),
    .hi       (hi),
    .busy     (busy),
    .done     (done),
    .div0     (div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check1(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
    end
  endtask

  // Issue one division at the next edge and check latency, busy, and the result.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int  n;
    bit  busy_ok;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);                 // E0
    #1;
    start    = 1'b0;
    dividend = 32'hDEAD_BEEF;       // latched values must be the ones used
    divisor  = 32'h0000_0000;
    check1({tag, " busy_after_start"}, busy, 1'b1);
    busy_ok = 1'b1;
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
      if (!busy || div0) busy_ok = 1'b0;
    end
    check32({tag, " latency"}, n, 33);
    check1({tag, " busy_held"}, busy_ok, 1'b1);
    check1({tag, " busy_low_at_done"}, busy, 1'b0);
    check32({tag, " lo"}, lo, exp_lo);
    check32({tag, " hi"}, hi, exp_hi);
    @(posedge clk);
    #1;
    check1({tag, " done_one_cycle"}, done, 1'b0);
  endtask

  initial begin
    int n;
    int dones;
    bit seen;

    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    check32("reset lo", lo, 32'h0);
    check32("reset hi", hi, 32'h0);
    check1("reset busy", busy, 1'b0);
    check1("reset done", done, 1'b0);
    check1("reset div0", div0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    run_div("7/2",   32'd7,          32'd2,          32'd3,          32'd1);
    run_div("-7/2",  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF);
    run_div("7/-2",  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1);
    run_div("-7/-2", 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF);
    run_div("ovf",   32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0);
    run_div("0/5",   32'd0,          32'd5,          32'd0,          32'd0);
    run_div("5/7",   32'd5,          32'd7,          32'd0,          32'd5);
    run_div("min/2", 32'h8000_0000,  32'd2,          32'hC000_0000,  32'd0);

    // Divide by zero: one-cycle div0, no busy, no done, results held from 5/7... then min/2.
    @(negedge clk);
    dividend = 32'd100;
    divisor  = 32'd0;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check1("div0 pulse", div0, 1'b1);
    check1("div0 busy", busy, 1'b0);
    check1("div0 done", done, 1'b0);
    @(posedge clk);
    #1;
    check1("div0 one_cycle", div0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen = 1'b1;
    end
    check1("div0 no_done", seen, 1'b0);
    check32("div0 lo_held", lo, 32'hC000_0000);
    check32("div0 hi_held", hi, 32'd0);

    // Ignored start and operand changes mid-run.
    @(negedge clk);
    dividend = 32'd7;
    divisor  = 32'd2;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    dones = 0;
    repeat (9) begin
      @(posedge clk);
      #1;
      n++;
    end
    dividend = 32'd100;
    divisor  = 32'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    n++;
    start    = 1'b0;
    dividend = 32'hFFFF_0000;
    divisor  = 32'd0;
    while (n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (done) begin
        dones++;
        check32("ign latency", n, 33);
        check32("ign lo", lo, 32'd3);
        check32("ign hi", hi, 32'd1);
      end
    end
    check32("ign single_done", dones, 1);

    // Reset mid-run.
    @(negedge clk);
    dividend = 32'd20;
    divisor  = 32'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check32("rst lo", lo, 32'd0);
    check32("rst hi", hi, 32'd0);
    check1("rst busy", busy, 1'b0);
    check1("rst done", done, 1'b0);
    check1("rst div0", div0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen = 1'b1;
    end
    check1("rst no_done", seen, 1'b0);

    run_div("9/4", 32'd9, 32'd4, 32'd2, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
